bsg_negedge_launch_fifo: RTL and testbench
==========================================

# bsg_negedge_launch_fifo

Ready/valid buffering FIFO that sits directly upstream of the 128-bit negative-edge reset register stage. It absorbs producer bursts on the rising edge and presents a registered head word that is stable for the full high phase of clk_i, ready for half-cycle capture on the following falling edge. Empty slots present all-zero data, so the downstream negedge register never captures stale words.

## Interface
- width_p, 128: data word width in bits.
- els_p, 4: FIFO depth in words, ≥2, need not be a power of two.
- clk_i  in  1  clock; all state updates on rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  producer word valid.
- data_i  in  width_p  producer word.
- ready_o  out  1  FIFO can accept a word this cycle.
- v_o  out  1  head word valid.
- data_o  out  width_p  head word; zero when v_o=0.
- ready_i  in  1  consumer takes head word this cycle.
- count_o  out  $clog2(els_p+1)  number of stored words.

## Operation
- Enqueue when v_i & ready_o at rising edge; dequeue when v_o & ready_i at rising edge.
- ready_o = (count != els_p); v_o = (count != 0). Both registered-state derived, no combinational path from v_i/ready_i.
- Storage: els_p x width_p array, write pointer wptr, read pointer rptr, count register.
- Pointers advance by 1 on their event, wrap from els_p-1 to 0.
- count: +1 on enq only, -1 on deq only, unchanged on both or neither.
- data_o driven from a registered head-word register, not directly from the array read mux: loaded with the next head (or array write data when enqueuing into an empty or about-to-be-empty FIFO), cleared to 0 when the FIFO becomes empty.
- Full and simultaneous v_i & ready_i: ready_o=0, no enqueue; dequeue proceeds; ready_o=1 next cycle.
- Empty and simultaneous v_i & ready_i: v_o=0, no dequeue; enqueue proceeds; v_o=1 next cycle. No fall-through.
- count=1 with simultaneous enq/deq: new word becomes head next cycle, v_o stays 1.
- Reset asserted mid-operation: all stored words discarded immediately. Array contents need not be cleared.

## Timing
- Reset values (asynchronous, while reset_n_i=0): wptr=0, rptr=0, count_o=0, v_o=0, ready_o=1, data_o=0.
- Reset release is synchronous-safe: first enqueue accepted at first rising edge after deassertion.
- Latency: word enqueued at edge N appears on data_o with v_o=1 after edge N, meaning it is available in cycle N+1. Minimum one cycle in to out.
- Throughput: one word per cycle, sustained indefinitely at any occupancy 1..els_p-1.
- data_o, v_o, ready_o and count_o are direct flop outputs or single-gate decodes of flops, so they are stable before the falling edge.

## Structure
- No shared package types are required. Local parameters only: ptr_width_lp = $clog2(els_p), count_width_lp = $clog2(els_p+1).
- One sub-module: bsg_circular_ptr_wrap. It is a pointer register with increment enable, wraps at els_p-1, and has async active-low reset. It is instantiated twice, for wptr and rptr.
- Storage array and head register are inline in the top module.

## Test plan
- Reset and idle: hold reset_n_i=0 with v_i=1 and data_i=all-ones -> v_o=0, data_o=0, ready_o=1, count_o=0. After release, a single enqueue of 0xA5 gives v_o=1 and data_o=0xA5 the next cycle.
- Fill to full (els_p=4): enqueue 1,2,3,4 with ready_i=0 -> count_o=4, ready_o=0. A fifth word 5 is ignored. Draining yields 1,2,3,4, then v_o=0 and data_o=0.
- Full plus simultaneous: at count=4, v_i=1 and ready_i=1 -> head 1 leaves, 9 is not accepted. count_o=3, ready_o=1 next cycle.
- Empty plus simultaneous: at count=0, v_i=1 with data 7 and ready_i=1 -> no dequeue. Next cycle v_o=1, data_o=7, count_o=1.
- Streaming wrap: 20 consecutive words 0..19 with v_i=ready_i=1 every cycle -> output sequence 0..19, each one cycle late. count_o stays at 1 and the pointers wrap 5 times.
- Reset mid-operation: at count=3, pull reset_n_i low mid-cycle -> v_o, count_o and data_o go to 0 immediately (asynchronously), and ready_o=1.

Source files
------------

// File: rtl/bsg_circular_ptr_wrap.sv
// Circular pointer register: advances by one when add_i is set and wraps from els_p-1 to 0.
// next_o exposes the post-increment value so the owner can look one slot ahead.
module bsg_circular_ptr_wrap #(
    parameter int els_p        = 4,
    parameter int ptr_width_lp = $clog2(els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    add_i,
    output logic [ptr_width_lp-1:0] ptr_o,
    output logic [ptr_width_lp-1:0] next_o
);

    logic [ptr_width_lp-1:0] ptr_q, ptr_d;

    assign next_o = (ptr_q == ptr_width_lp'(els_p - 1)) ? '0 : ptr_q + ptr_width_lp'(1);
    assign ptr_d  = add_i ? next_o : ptr_q;
    assign ptr_o  = ptr_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bsg_negedge_launch_fifo.sv
// Ready/valid FIFO with a registered, zero-when-empty head word so data_o is stable
// through the high phase of clk_i for capture by the downstream negedge register.
module bsg_negedge_launch_fifo #(
    parameter int width_p = 128,
    parameter int els_p   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         v_i,
    input  logic [width_p-1:0]           data_i,
    output logic                         ready_o,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         ready_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_width_lp   = $clog2(els_p);
    localparam int count_width_lp = $clog2(els_p + 1);

    logic [width_p-1:0]        mem_q [els_p];
    logic [width_p-1:0]        head_q, head_d;
    logic [count_width_lp-1:0] count_q, count_d;
    logic [ptr_width_lp-1:0]   wptr, rptr, rptr_next;
    logic [ptr_width_lp-1:0]   wptr_next_unused;
    logic                      enq, deq;

    assign ready_o = (count_q != count_width_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign enq     = v_i & ready_o;
    assign deq     = v_o & ready_i;
    assign data_o  = head_q;
    assign count_o = count_q;

    bsg_circular_ptr_wrap #(.els_p(els_p)) u_wptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .add_i     (enq),
        .ptr_o     (wptr),
        .next_o    (wptr_next_unused)
    );

    bsg_circular_ptr_wrap #(.els_p(els_p)) u_rptr (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .add_i     (deq),
        .ptr_o     (rptr),
        .next_o    (rptr_next)
    );

    // Head is a copy of mem_q[rptr]; with one word left and an enqueue, the
    // incoming word is the only candidate since the array slot is not yet written.
    always_comb begin
        count_d = count_q;
        if (enq && !deq)      count_d = count_q + count_width_lp'(1);
        else if (deq && !enq) count_d = count_q - count_width_lp'(1);

        head_d = head_q;
        if (count_d == '0)
            head_d = '0;
        else if (deq)
            head_d = (count_q == count_width_lp'(1)) ? data_i : mem_q[rptr_next];
        else if (count_q == '0)
            head_d = data_i;
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wptr] <= data_i;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
            head_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

endmodule

// File: tb/tb_bsg_negedge_launch_fifo.sv
// Directed bench for bsg_negedge_launch_fifo: queue-based model checked every falling
// edge, plus literal expectations from hand-worked scenarios.
module tb_bsg_negedge_launch_fifo;

    localparam int W = 128;
    localparam int E = 4;

    logic          clk = 1'b0;
    logic          reset_n_i;
    logic          v_i, ready_i;
    logic [W-1:0]  data_i;
    logic          ready_o, v_o;
    logic [W-1:0]  data_o;
    logic [2:0]    count_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] q [$];

    always #5 clk = ~clk;

    bsg_negedge_launch_fifo #(.width_p(W), .els_p(E)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .ready_o   (ready_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .ready_i   (ready_i),
        .count_o   (count_o)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the FIFO is simply an ordered list of stored words, capped at E.
    always @(posedge clk) begin
        if (reset_n_i) begin
            bit can_deq, can_enq;
            can_deq = (q.size() != 0) && ready_i;
            can_enq = (q.size() != E) && v_i;
            if (can_deq) void'(q.pop_front());
            if (can_enq) q.push_back(data_i);
        end
    end

    always @(negedge reset_n_i) q.delete();

    always @(negedge clk) begin
        chk("m_v_o",     {127'd0, v_o},     {127'd0, q.size() != 0});
        chk("m_ready_o", {127'd0, ready_o}, {127'd0, q.size() != E});
        chk("m_count_o", {125'd0, count_o}, W'(q.size()));
        chk("m_data_o",  data_o,            (q.size() != 0) ? q[0] : '0);
    end

    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        v_i = v; data_i = d; ready_i = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n_i = 1'b0;
        v_i = 1'b1; data_i = '1; ready_i = 1'b0;
        #12;
        chk("rst_v_o",     {127'd0, v_o},     '0);
        chk("rst_data_o",  data_o,            '0);
        chk("rst_ready_o", {127'd0, ready_o}, W'(1));
        chk("rst_count_o", {125'd0, count_o}, '0);
        @(negedge clk);
        reset_n_i = 1'b1;

        // first edge after release accepts a word
        step(1'b1, W'('hA5), 1'b0);
        chk("a5_v_o",    {127'd0, v_o}, W'(1));
        chk("a5_data_o", data_o,        W'('hA5));
        step(1'b0, '0, 1'b1);
        chk("a5_drain_v_o", {127'd0, v_o}, '0);

        // fill to full, overflow word ignored, drain in order
        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0);
        chk("full_count",   {125'd0, count_o}, W'(4));
        chk("full_ready_o", {127'd0, ready_o}, '0);
        step(1'b1, W'(5), 1'b0);
        chk("ovf_count", {125'd0, count_o}, W'(4));
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", data_o, W'(i));
            step(1'b0, '0, 1'b1);
        end
        chk("drained_v_o",    {127'd0, v_o}, '0);
        chk("drained_data_o", data_o,        '0);

        // full with simultaneous enq/deq: only the dequeue happens
        for (int i = 1; i <= 4; i++) step(1'b1, W'(i), 1'b0);
        step(1'b1, W'(9), 1'b1);
        chk("fs_count",   {125'd0, count_o}, W'(3));
        chk("fs_ready_o", {127'd0, ready_o}, W'(1));
        chk("fs_head",    data_o,            W'(2));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);

        // empty with simultaneous enq/deq: no fall-through
        step(1'b1, W'(7), 1'b1);
        chk("es_v_o",   {127'd0, v_o},     W'(1));
        chk("es_data",  data_o,            W'(7));
        chk("es_count", {125'd0, count_o}, W'(1));
        step(1'b0, '0, 1'b1);

        // streaming: head lags the input by one cycle, occupancy stays 1
        for (int i = 0; i < 20; i++) begin
            step(1'b1, W'(i), 1'b1);
            chk("st_data",  data_o,            W'(i));
            chk("st_count", {125'd0, count_o}, W'(1));
        end
        step(1'b0, '0, 1'b1);

        // asynchronous reset with three words stored
        for (int i = 0; i < 3; i++) step(1'b1, W'(32'hC0 + i), 1'b0);
        chk("pre_rst_count", {125'd0, count_o}, W'(3));
        v_i = 1'b0;
        @(posedge clk);
        #2 reset_n_i = 1'b0;
        #1;
        chk("arst_v_o",     {127'd0, v_o},     '0);
        chk("arst_count",   {125'd0, count_o}, '0);
        chk("arst_data_o",  data_o,            '0);
        chk("arst_ready_o", {127'd0, ready_o}, W'(1));
        @(negedge clk);
        reset_n_i = 1'b1;
        step(1'b1, W'('h3C), 1'b0);
        chk("post_rst_data", data_o, W'('h3C));
        step(1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
